// File: rtl/hazard_tracker_pkg.sv
// Shared encodings for the hazard tracker: operand-unused marker,
// decoder Tnew constants and forwarding-mux select values.
package hazard_tracker_pkg;

  localparam logic [3:0] TUSE_NONE = 4'hf;

  localparam logic [3:0] TNEW_ZERO = 4'd0;
  localparam logic [3:0] TNEW_ALU  = 4'd1;
  localparam logic [3:0] TNEW_LOAD = 4'd2;

  localparam logic [1:0] FWD_D_GRF  = 2'd0;
  localparam logic [1:0] FWD_D_E    = 2'd1;
  localparam logic [1:0] FWD_D_M    = 2'd2;
  localparam logic [1:0] FWD_D_W    = 2'd3;

  localparam logic [1:0] FWD_E_PIPE = 2'd0;
  localparam logic [1:0] FWD_E_M    = 2'd1;
  localparam logic [1:0] FWD_E_W    = 2'd2;

  localparam logic       FWD_M_PIPE = 1'b0;
  localparam logic       FWD_M_W    = 1'b1;

endpackage

// File: rtl/hazard_tracker_fwd_sel.sv
// Priority forwarding select over up to three producer stages, youngest first.
// A producer still computing (Tnew>0) is skipped so older stages can supply the value.
module hazard_fwd_sel
  import hazard_tracker_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int T_W    = 4
)(
  input  logic [REG_AW-1:0] i_src,
  input  logic [REG_AW-1:0] i_a3_0,
  input  logic [T_W-1:0]    i_tnew_0,
  input  logic [REG_AW-1:0] i_a3_1,
  input  logic [T_W-1:0]    i_tnew_1,
  input  logic [REG_AW-1:0] i_a3_2,
  output logic [1:0]        o_sel
);

  always_comb begin
    o_sel = FWD_D_GRF;
    if (i_src != '0) begin
      if (i_src == i_a3_0 && i_tnew_0 == '0)
        o_sel = FWD_D_E;
      else if (i_src == i_a3_1 && i_tnew_1 == '0)
        o_sel = FWD_D_M;
      else if (i_src == i_a3_2)
        o_sel = FWD_D_W;
    end
  end

endmodule

// File: rtl/hazard_tracker.sv
// D-stage hazard unit: shadows E/M/W destinations with remaining Tnew,
// raises the D stall and drives the D/E/M forwarding selects.
module hazard_tracker
  import hazard_tracker_pkg::*;
#(
  parameter int              REG_AW    = 5,
  parameter int              T_W       = 4,
  parameter logic [T_W-1:0]  TUSE_NONE = hazard_tracker_pkg::TUSE_NONE
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] D_rs,
  input  logic [REG_AW-1:0] D_rt,
  input  logic [T_W-1:0]    D_Tuse_RS,
  input  logic [T_W-1:0]    D_Tuse_RT,
  input  logic [REG_AW-1:0] D_A3,
  input  logic              D_RegWrite,
  input  logic [T_W-1:0]    D_Tnew,
  output logic              stall,
  output logic [1:0]        D_fwd_rs,
  output logic [1:0]        D_fwd_rt,
  output logic [1:0]        E_fwd_rs,
  output logic [1:0]        E_fwd_rt,
  output logic              M_fwd_rt
);

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] x);
    return (x != '0) ? (x - T_W'(1)) : '0;
  endfunction

  logic [REG_AW-1:0] r_E_rs, r_E_rt, r_E_A3;
  logic [T_W-1:0]    r_E_Tnew;
  logic [REG_AW-1:0] r_M_rt, r_M_A3;
  logic [T_W-1:0]    r_M_Tnew;
  logic [REG_AW-1:0] r_W_A3;

  logic [REG_AW-1:0] w_D_A3_q;
  logic              w_stall_rs, w_stall_rt;

  // A3 of zero doubles as "no producer", so $0 writes never create hazards.
  assign w_D_A3_q = (D_RegWrite && D_A3 != '0) ? D_A3 : '0;

  assign w_stall_rs = (D_rs != '0) && (D_Tuse_RS != TUSE_NONE) &&
                      ((D_rs == r_E_A3 && D_Tuse_RS < r_E_Tnew) ||
                       (D_rs == r_M_A3 && D_Tuse_RS < r_M_Tnew));
  assign w_stall_rt = (D_rt != '0) && (D_Tuse_RT != TUSE_NONE) &&
                      ((D_rt == r_E_A3 && D_Tuse_RT < r_E_Tnew) ||
                       (D_rt == r_M_A3 && D_Tuse_RT < r_M_Tnew));
  assign stall = w_stall_rs | w_stall_rt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_E_rs   <= '0;
      r_E_rt   <= '0;
      r_E_A3   <= '0;
      r_E_Tnew <= '0;
      r_M_rt   <= '0;
      r_M_A3   <= '0;
      r_M_Tnew <= '0;
      r_W_A3   <= '0;
    end else begin
      if (stall) begin
        r_E_rs   <= '0;
        r_E_rt   <= '0;
        r_E_A3   <= '0;
        r_E_Tnew <= '0;
      end else begin
        r_E_rs   <= D_rs;
        r_E_rt   <= D_rt;
        r_E_A3   <= w_D_A3_q;
        r_E_Tnew <= D_Tnew;
      end
      r_M_rt   <= r_E_rt;
      r_M_A3   <= r_E_A3;
      r_M_Tnew <= sat_dec(r_E_Tnew);
      r_W_A3   <= r_M_A3;
    end
  end

  hazard_fwd_sel #(.REG_AW(REG_AW), .T_W(T_W)) u_d_rs (
    .i_src(D_rs), .i_a3_0(r_E_A3), .i_tnew_0(r_E_Tnew),
    .i_a3_1(r_M_A3), .i_tnew_1(r_M_Tnew), .i_a3_2(r_W_A3), .o_sel(D_fwd_rs)
  );
  hazard_fwd_sel #(.REG_AW(REG_AW), .T_W(T_W)) u_d_rt (
    .i_src(D_rt), .i_a3_0(r_E_A3), .i_tnew_0(r_E_Tnew),
    .i_a3_1(r_M_A3), .i_tnew_1(r_M_Tnew), .i_a3_2(r_W_A3), .o_sel(D_fwd_rt)
  );

  // E consumers see M as the youngest producer; W always has its result ready.
  hazard_fwd_sel #(.REG_AW(REG_AW), .T_W(T_W)) u_e_rs (
    .i_src(r_E_rs), .i_a3_0(r_M_A3), .i_tnew_0(r_M_Tnew),
    .i_a3_1(r_W_A3), .i_tnew_1('0), .i_a3_2('0), .o_sel(E_fwd_rs)
  );
  hazard_fwd_sel #(.REG_AW(REG_AW), .T_W(T_W)) u_e_rt (
    .i_src(r_E_rt), .i_a3_0(r_M_A3), .i_tnew_0(r_M_Tnew),
    .i_a3_1(r_W_A3), .i_tnew_1('0), .i_a3_2('0), .o_sel(E_fwd_rt)
  );

  assign M_fwd_rt = (r_M_rt != '0 && r_M_rt == r_W_A3) ? FWD_M_W : FWD_M_PIPE;

endmodule
